rs_encoder: RTL and testbench

Systematic RS(7,3) encoder over GF(8), the stage directly upstream of the RS decoder/corrector path. It accepts one 9-bit message (3 symbols) and produces a 21-bit codeword (3 message symbols followed by 4 parity symbols) in the same symbol format the decoder consumes. Parity is computed serially in a 4-stage GF(8) LFSR, one message symbol per clock. Valid/ready handshakes are used on both sides.

---
 rtl/rs_pkg.sv | 73 +++++++
 rtl/rs_enc_lfsr.sv | 76 +++++++
 rtl/rs_encoder.sv | 138 +++++++++++++
 tb/tb_rs_encoder.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rs_pkg.sv
// Shared definitions for the RS(7,3) encoder over GF(8).
// Symbols travel in index form: 0 = zero, k in 1..7 = alpha^(k-1).
// Arithmetic uses polynomial form with primitive polynomial x^3 + x + 1.
package rs_pkg;

    localparam int SYM_W = 3;
    localparam int N     = 7;
    localparam int K     = 3;

    typedef logic [SYM_W-1:0] sym_t;

    // Generator g(x) = x^4 + a^3 x^3 + x^2 + a x + a^3, coefficients in index form
    localparam sym_t G3 = 3'd4;
    localparam sym_t G2 = 3'd1;
    localparam sym_t G1 = 3'd2;
    localparam sym_t G0 = 3'd4;

    typedef enum logic [1:0] {
        ENC_IDLE  = 2'd0,
        ENC_SHIFT = 2'd1,
        ENC_DONE  = 2'd2
    } enc_state_t;

    // Index form -> polynomial form
    function automatic sym_t idx2poly(input sym_t idx);
        sym_t p;
        case (idx)
            3'd0:    p = 3'b000;
            3'd1:    p = 3'b001;
            3'd2:    p = 3'b010;
            3'd3:    p = 3'b100;
            3'd4:    p = 3'b011;
            3'd5:    p = 3'b110;
            3'd6:    p = 3'b111;
            default: p = 3'b101;
        endcase
        return p;
    endfunction

    // Polynomial form -> index form
    function automatic sym_t poly2idx(input sym_t p);
        sym_t idx;
        case (p)
            3'b000:  idx = 3'd0;
            3'b001:  idx = 3'd1;
            3'b010:  idx = 3'd2;
            3'b100:  idx = 3'd3;
            3'b011:  idx = 3'd4;
            3'b110:  idx = 3'd5;
            3'b111:  idx = 3'd6;
            default: idx = 3'd7;
        endcase
        return idx;
    endfunction

    // Carry-less multiply of two polynomial-form symbols, reduced by x^3 + x + 1
    function automatic sym_t gf_mul_poly(input sym_t a, input sym_t b);
        logic [4:0] prod;
        prod = '0;
        for (int i = 0; i < 3; i++) begin
            if (b[i]) begin
                prod = prod ^ ({2'b00, a} << i);
            end
        end
        for (int k = 4; k >= 3; k--) begin
            if (prod[k]) begin
                prod = prod ^ (5'b01011 << (k - 3));
            end
        end
        return prod[2:0];
    endfunction

endpackage

// File: rtl/rs_enc_lfsr.sv
// Four-stage GF(8) parity LFSR for the RS(7,3) encoder.
// Registers r3..r0 hold polynomial-form values. Besides the register view,
// the post-shift values are exposed so the caller can capture the parity of
// the final symbol on the same edge that shifts it in.
module rs_enc_lfsr
    import rs_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n_i,
    input  logic             clear_i,
    input  logic             shift_i,
    input  logic [SYM_W-1:0] sym_i,
    output logic [SYM_W-1:0] r3_o,
    output logic [SYM_W-1:0] r2_o,
    output logic [SYM_W-1:0] r1_o,
    output logic [SYM_W-1:0] r0_o,
    output logic [SYM_W-1:0] nxt3_o,
    output logic [SYM_W-1:0] nxt2_o,
    output logic [SYM_W-1:0] nxt1_o,
    output logic [SYM_W-1:0] nxt0_o
);

    sym_t r3_q, r2_q, r1_q, r0_q;
    sym_t r3_d, r2_d, r1_d, r0_d;
    sym_t fb;
    sym_t sh3, sh2, sh1, sh0;

    // Feedback and shifted values, then choose hold / clear / shift
    always_comb begin
        fb  = idx2poly(sym_i) ^ r3_q;
        sh3 = r2_q ^ gf_mul_poly(fb, idx2poly(G3));
        sh2 = r1_q ^ gf_mul_poly(fb, idx2poly(G2));
        sh1 = r0_q ^ gf_mul_poly(fb, idx2poly(G1));
        sh0 = gf_mul_poly(fb, idx2poly(G0));
        r3_d = r3_q;
        r2_d = r2_q;
        r1_d = r1_q;
        r0_d = r0_q;
        if (clear_i) begin
            r3_d = '0;
            r2_d = '0;
            r1_d = '0;
            r0_d = '0;
        end else if (shift_i) begin
            r3_d = sh3;
            r2_d = sh2;
            r1_d = sh1;
            r0_d = sh0;
        end
    end

    // Parity registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n_i) begin
            r3_q <= '0;
            r2_q <= '0;
            r1_q <= '0;
            r0_q <= '0;
        end else begin
            r3_q <= r3_d;
            r2_q <= r2_d;
            r1_q <= r1_d;
            r0_q <= r0_d;
        end
    end

    assign r3_o   = r3_q;
    assign r2_o   = r2_q;
    assign r1_o   = r1_q;
    assign r0_o   = r0_q;
    assign nxt3_o = sh3;
    assign nxt2_o = sh2;
    assign nxt1_o = sh1;
    assign nxt0_o = sh0;

endmodule

// File: rtl/rs_encoder.sv
// Systematic RS(7,3) encoder over GF(8) with valid/ready on both sides.
// One message symbol enters the parity LFSR per clock (m2, m1, m0); the
// codeword {m2,m1,m0,p3,p2,p1,p0} is registered on the edge that shifts m0.
// Optional build macro RS_ENC_ERR_INJECT_EN adds inj_en/inj_pos/inj_sym to
// overwrite one codeword symbol when the codeword is captured.
module rs_encoder
    import rs_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [K*SYM_W-1:0]   msg,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N*SYM_W-1:0]   codeword
`ifdef RS_ENC_ERR_INJECT_EN
    ,
    input  logic                 inj_en,
    input  logic [2:0]           inj_pos,
    input  logic [SYM_W-1:0]     inj_sym
`endif
);

    enc_state_t             state_q, state_d;
    logic [1:0]             cnt_q, cnt_d;
    logic [K*SYM_W-1:0]     msg_q, msg_d;
    logic [N*SYM_W-1:0]     codeword_q, codeword_d;

    logic                   lfsr_clear;
    logic                   lfsr_shift;
    sym_t                   lfsr_sym;
    sym_t                   r3, r2, r1, r0;
    sym_t                   nxt3, nxt2, nxt1, nxt0;
    logic [N*SYM_W-1:0]     clean_cw;
    logic [N*SYM_W-1:0]     final_cw;

    rs_enc_lfsr u_lfsr (
        .clk     (clk),
        .rst_n_i (reset),
        .clear_i (lfsr_clear),
        .shift_i (lfsr_shift),
        .sym_i   (lfsr_sym),
        .r3_o    (r3),
        .r2_o    (r2),
        .r1_o    (r1),
        .r0_o    (r0),
        .nxt3_o  (nxt3),
        .nxt2_o  (nxt2),
        .nxt1_o  (nxt1),
        .nxt0_o  (nxt0)
    );

    // The register view is not needed here: parity is taken from the
    // post-shift values so it lands on the same edge as the last symbol.
    logic unused_lfsr_regs;
    assign unused_lfsr_regs = ^{r3, r2, r1, r0};

    // Message symbol fed this cycle: highest degree first
    always_comb begin
        case (cnt_q)
            2'd0:    lfsr_sym = msg_q[8:6];
            2'd1:    lfsr_sym = msg_q[5:3];
            default: lfsr_sym = msg_q[2:0];
        endcase
    end

    assign clean_cw = {msg_q, poly2idx(nxt3), poly2idx(nxt2),
                       poly2idx(nxt1), poly2idx(nxt0)};

`ifdef RS_ENC_ERR_INJECT_EN
    // Per-position symbol replacement; inj_pos = 7 matches nothing
    for (genvar gi = 0; gi < N; gi++) begin : g_inject
        assign final_cw[gi*SYM_W +: SYM_W] =
            (inj_en && (inj_pos == 3'(gi))) ? inj_sym
                                            : clean_cw[gi*SYM_W +: SYM_W];
    end
`else
    assign final_cw = clean_cw;
`endif

    // Next-state and control decode for IDLE -> SHIFT -> DONE
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        msg_d      = msg_q;
        codeword_d = codeword_q;
        lfsr_clear = 1'b0;
        lfsr_shift = 1'b0;
        case (state_q)
            ENC_IDLE: begin
                if (in_valid) begin
                    msg_d      = msg;
                    cnt_d      = 2'd0;
                    lfsr_clear = 1'b1;
                    state_d    = ENC_SHIFT;
                end
            end
            ENC_SHIFT: begin
                lfsr_shift = 1'b1;
                cnt_d      = cnt_q + 2'd1;
                if (cnt_q == 2'd2) begin
                    codeword_d = final_cw;
                    cnt_d      = 2'd0;
                    state_d    = ENC_DONE;
                end
            end
            ENC_DONE: begin
                if (out_ready) begin
                    state_d = ENC_IDLE;
                end
            end
            default: begin
                state_d = ENC_IDLE;
            end
        endcase
    end

    // State, counter, message latch and codeword with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ENC_IDLE;
            cnt_q      <= '0;
            msg_q      <= '0;
            codeword_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            msg_q      <= msg_d;
            codeword_q <= codeword_d;
        end
    end

    assign in_ready  = (state_q == ENC_IDLE);
    assign out_valid = (state_q == ENC_DONE);
    assign codeword  = codeword_q;

endmodule

// File: tb/tb_rs_encoder.sv
// Directed and table-driven bench for rs_encoder. Expected codewords are
// hand-computed; random messages are checked by evaluating the received
// codeword polynomial at a^1..a^4 with index-form exponent arithmetic.
// Define RS_ENC_ERR_INJECT_EN to exercise the injection ports.
module tb_rs_encoder;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [8:0]  msg;
    logic        out_valid;
    logic        out_ready;
    logic [20:0] codeword;
`ifdef RS_ENC_ERR_INJECT_EN
    logic        inj_en;
    logic [2:0]  inj_pos;
    logic [2:0]  inj_sym;
`endif

    int checks;
    int errors;

    typedef struct {
        logic [8:0]  m;
        logic [20:0] cw;
    } vec_t;

    vec_t       vecs[6];
    logic [2:0] pow_tab[7];

    rs_encoder dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .msg       (msg),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .codeword  (codeword)
`ifdef RS_ENC_ERR_INJECT_EN
        ,
        .inj_en    (inj_en),
        .inj_pos   (inj_pos),
        .inj_sym   (inj_sym)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0o expected %0o", name, act, exp);
        end
    endtask

    // Syndromes S1..S4 packed as {S4,S3,S2,S1}, each in polynomial form
    function automatic logic [11:0] syndromes(input logic [20:0] cw);
        logic [11:0] res;
        logic [2:0]  acc;
        logic [2:0]  c;
        res = '0;
        for (int j = 1; j <= 4; j++) begin
            acc = '0;
            for (int i = 0; i < 7; i++) begin
                c = cw[3*i +: 3];
                if (c != 3'd0) begin
                    acc = acc ^ pow_tab[(int'(c) - 1 + j*i) % 7];
                end
            end
            res[3*(j-1) +: 3] = acc;
        end
        return res;
    endfunction

    // Full transaction: accept, wait for out_valid (bounded), hand off
    task automatic encode(input logic [8:0] m, output logic [20:0] cw);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        check("ready_before_accept", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        msg      = m;
        @(posedge clk); #1;
        in_valid = 1'b0;
        msg      = 9'($urandom);
        check("busy_after_accept", 32'(in_ready), 32'd0);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1; n++;
        end
        check("latency", 32'(n), 32'd3);
        cw = codeword;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("handoff_valid_drop", 32'(out_valid), 32'd0);
        check("handoff_ready", 32'(in_ready), 32'd1);
        $display("txn msg=%03o codeword=%07o latency=%0d", m, cw, n);
    endtask

    initial begin
        logic [20:0] cw;
        logic [8:0]  rm;
        logic [2:0]  p;
        int          n;

        checks = 0;
        errors = 0;

        p = 3'b001;
        for (int e = 0; e < 7; e++) begin
            pow_tab[e] = p;
            p = {p[1:0], 1'b0} ^ (p[2] ? 3'b011 : 3'b000);
        end

        vecs[0] = '{m: 9'o000, cw: 21'o0000000};
        vecs[1] = '{m: 9'o001, cw: 21'o0014124};
        vecs[2] = '{m: 9'o010, cw: 21'o0103177};
        vecs[3] = '{m: 9'o100, cw: 21'o1005156};
        vecs[4] = '{m: 9'o011, cw: 21'o0116065};
        vecs[5] = '{m: 9'o002, cw: 21'o0025235};

        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        msg       = '0;
`ifdef RS_ENC_ERR_INJECT_EN
        inj_en  = 1'b0;
        inj_pos = 3'd7;
        inj_sym = 3'd0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_codeword", 32'(codeword), 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        // Table-driven directed vectors
        for (int v = 0; v < 6; v++) begin
            encode(vecs[v].m, cw);
            check($sformatf("vec%0d_codeword", v), 32'(cw), 32'(vecs[v].cw));
        end

        // Random messages: systematic part and zero syndromes
        for (int t = 0; t < 100; t++) begin
            rm = 9'($urandom);
            encode(rm, cw);
            check("rand_systematic", 32'(cw[20:12]), 32'(rm));
            check("rand_syndrome", 32'(syndromes(cw)), 32'd0);
        end

        // Back-pressure: hold DONE for 10 cycles with ignored in_valid pulses
        in_valid = 1'b1;
        msg      = 9'o001;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1; n++;
        end
        check("hold_latency", 32'(n), 32'd3);
        for (int c = 0; c < 10; c++) begin
            in_valid = c[0];
            msg      = 9'o777;
            @(posedge clk); #1;
            check("hold_codeword", 32'(codeword), 32'o0014124);
            check("hold_out_valid", 32'(out_valid), 32'd1);
            check("hold_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("hold_release_valid", 32'(out_valid), 32'd0);
        check("hold_release_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        check("hold_no_stray_accept", 32'(in_ready), 32'd1);
        $display("txn hold msg=001 released after 10 stalled cycles");

        // Reset during the second SHIFT cycle drops the message
        in_valid = 1'b1;
        msg      = 9'o777;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        check("midreset_out_valid", 32'(out_valid), 32'd0);
        check("midreset_in_ready", 32'(in_ready), 32'd1);
        check("midreset_codeword", 32'(codeword), 32'd0);
        repeat (5) @(posedge clk);
        #1;
        check("midreset_dropped", 32'(out_valid), 32'd0);
        $display("txn reset during SHIFT, message 777 dropped");
        encode(9'o010, cw);
        check("post_reset_codeword", 32'(cw), 32'o0103177);

        // Reset while in DONE
        in_valid = 1'b1;
        msg      = 9'o001;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("done_reset_pre_valid", 32'(out_valid), 32'd1);
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        check("done_reset_valid", 32'(out_valid), 32'd0);
        check("done_reset_codeword", 32'(codeword), 32'd0);
        $display("txn reset in DONE, codeword cleared");

`ifdef RS_ENC_ERR_INJECT_EN
        inj_en  = 1'b1;
        inj_pos = 3'd6;
        inj_sym = 3'd3;
        encode(9'o001, cw);
        check("inject_pos6", 32'(cw), 32'o3014124);
        inj_pos = 3'd0;
        inj_sym = 3'd0;
        encode(9'o001, cw);
        check("inject_pos0", 32'(cw), 32'o0014120);
        inj_pos = 3'd7;
        inj_sym = 3'd5;
        encode(9'o001, cw);
        check("inject_pos7_none", 32'(cw), 32'o0014124);
        inj_en = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
